// File: rtl/idct8_stream.sv
// Streaming 8-point inverse DCT: eight sign-magnitude coefficients in, eight
// reconstructed sign-magnitude samples out, with all eight sums built on the fly.
module idct8_stream (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a source holds data stable while valid && !ready.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FINAL  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [2:0]         n_q, n_d;
  logic [2:0]         n_nxt;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic signed [28:0] coef_q, coef_d;
  logic [2:0]         coef_k_q, coef_k_d;
  logic               coef_vld_q, coef_vld_d;
  logic signed [28:0] acc_q [8];
  logic signed [28:0] acc_d [8];
  logic               in_fire;
  logic               out_fire;

  function automatic int cmag(input int i);
    int c;
    case (i)
      1:       c = 501;
      2:       c = 471;
      3:       c = 430;
      4:       c = 358;
      5:       c = 286;
      6:       c = 194;
      7:       c = 102;
      default: c = 0;
    endcase
    return c;
  endfunction

  // Fold the cosine phase (2n+1)k into the first quadrant of the table.
  function automatic logic signed [28:0] weight(input int k, input int n);
    int j;
    int idx;
    int c;
    if (k == 0) begin
      return 29'sd358;
    end
    j = ((2 * n + 1) * k) % 32;
    if (j > 16) j = 32 - j;
    idx = (j < 8) ? j : 16 - j;
    c = cmag(idx);
    return (j < 8) ? 29'(c) : 29'(-c);
  endfunction

  function automatic logic [15:0] conv(input logic signed [28:0] a);
    logic [28:0] abs_v;
    logic [18:0] shr;
    logic [14:0] mag;
    abs_v = a[28] ? $unsigned(-a) : $unsigned(a);
    shr   = 19'(abs_v >> 10);
    mag   = (shr > 19'd32767) ? 15'h7fff : shr[14:0];
    return (mag == 15'd0) ? 16'h0000 : {a[28], mag};
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign n_nxt    = n_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    coef_d      = coef_q;
    coef_k_d    = coef_k_q;
    coef_vld_d  = 1'b0;

    // The coefficient registered on the accept edge is folded in one cycle later.
    for (int n = 0; n < 8; n++) begin
      acc_d[n] = coef_vld_q ? acc_q[n] + coef_q * weight(int'(coef_k_q), n) : acc_q[n];
    end

    case (state_q)
      ST_LOAD: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          coef_vld_d = 1'b1;
          coef_k_d   = k_q;
          coef_d     = in_data[15] ? -$signed({14'd0, in_data[14:0]})
                                   :  $signed({14'd0, in_data[14:0]});
          if (k_q == 3'd7) begin
            k_d        = 3'd0;
            in_ready_d = 1'b0;
            state_d    = ST_FINAL;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      ST_FINAL: begin
        n_d     = 3'd0;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = conv(acc_q[0]);
          out_last_d  = 1'b0;
          n_d         = 3'd0;
        end else if (out_fire) begin
          if (n_q == 3'd7) begin
            out_valid_d = 1'b0;
            out_data_d  = 16'h0000;
            out_last_d  = 1'b0;
            n_d         = 3'd0;
            k_d         = 3'd0;
            in_ready_d  = 1'b1;
            state_d     = ST_LOAD;
            for (int n = 0; n < 8; n++) acc_d[n] = '0;
          end else begin
            n_d        = n_nxt;
            out_data_d = conv(acc_q[n_nxt]);
            out_last_d = (n_nxt == 3'd7);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_last_q  <= 1'b0;
      coef_q      <= '0;
      coef_k_q    <= 3'd0;
      coef_vld_q  <= 1'b0;
      for (int n = 0; n < 8; n++) acc_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      coef_q      <= coef_d;
      coef_k_q    <= coef_k_d;
      coef_vld_q  <= coef_vld_d;
      for (int n = 0; n < 8; n++) acc_q[n] <= acc_d[n];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_idct8_stream.sv
// Bench for idct8_stream: directed blocks with hand-derived samples plus random
// streaming against a cosine-derived reference model.
module tb_idct8_stream;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [1:0]  dbg_state;

  int   n_vec = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  bit   mon_en = 1'b1;
  bit   rdy_auto = 1'b0;
  int   rdy_pct = 100;
  logic [16:0] exp_q[$];

  idct8_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d samples still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: weight sign and magnitude come from the real cosine
  // cos(pi*(2n+1)k/16), matched to the nearest entry of the constant table.
  function automatic int wt(input int k, input int n);
    int  tbl[8] = '{0, 501, 471, 430, 358, 286, 194, 102};
    real c, ac, d, best_d;
    int  best;
    if (k == 0) return 358;
    c  = $cos(PI * real'((2 * n + 1) * k) / 16.0);
    ac = (c < 0.0) ? -c : c;
    best = 1;
    best_d = 10.0;
    for (int i = 1; i < 8; i++) begin
      d = ac - $cos(PI * real'(i) / 16.0);
      if (d < 0.0) d = -d;
      if (d < best_d) begin
        best_d = d;
        best = i;
      end
    end
    return (c < 0.0) ? -tbl[best] : tbl[best];
  endfunction

  function automatic logic [15:0] model_sample(input logic [15:0] x[8], input int n);
    longint sum, v, mag;
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      v = longint'(x[k][14:0]);
      if (x[k][15]) v = -v;
      sum += v * longint'(wt(k, n));
    end
    mag = (sum < 0) ? -sum : sum;
    mag = mag / 1024;
    if (mag > 32767) mag = 32767;
    if (mag == 0) return 16'h0000;
    return {(sum < 0) ? 1'b1 : 1'b0, 15'(mag)};
  endfunction

  function automatic logic [15:0] rand_coef();
    logic [14:0] m;
    case ($urandom_range(0, 3))
      0:       m = 15'($urandom_range(0, 255));
      1:       m = 15'($urandom_range(0, 32767));
      2:       m = 15'd0;
      default: m = 15'($urandom_range(0, 4095));
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // Scoreboard feeders
  task automatic push_model(input logic [15:0] blk[8]);
    for (int n = 0; n < 8; n++) exp_q.push_back({(n == 7) ? 1'b1 : 1'b0, model_sample(blk, n)});
  endtask

  task automatic push_lit(input logic [15:0] v[8]);
    for (int n = 0; n < 8; n++) exp_q.push_back({(n == 7) ? 1'b1 : 1'b0, v[n]});
  endtask

  // Drivers: called and return at posedge+1
  task automatic send_coef(input logic [15:0] d, input int gap_max);
    bit got;
    int gap;
    gap = $urandom_range(0, gap_max);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    got = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("in_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic send_block(input logic [15:0] blk[8], input int gap_max);
    for (int k = 0; k < 8; k++) send_coef(blk[k], gap_max);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_auto) out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Compare process: every output handshake is checked against the queue head.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) check("in_ready_low_while_output", in_ready, 1'b0);
      if (!reset && out_valid && out_ready) begin
        hs_cnt++;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sample", {15'd0, out_last, out_data}, 32'h1ffff);
          end else begin
            e = exp_q.pop_front();
            check("sample_data", out_data, e[15:0]);
            check("sample_last", out_last, e[16]);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] blk[8];
    logic [15:0] lit[8];
    bit got;

    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 16'h0000);
    check("reset_out_last", out_last, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_before_first_edge", in_ready, 1'b0);
    @(negedge clk);
    check("in_ready_after_first_edge", in_ready, 1'b1);

    // Pin the model against hand-derived values
    blk = '{16'd800, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    check("model_dc", model_sample(blk, 3), 16'h0117);
    blk = '{16'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    check("model_ac_n1", model_sample(blk, 1), 16'h01A3);
    check("model_ac_n4", model_sample(blk, 4), 16'h8063);
    check("model_ac_n7", model_sample(blk, 7), 16'h81E9);
    blk = '{8{16'h7FFF}};
    check("model_sat", model_sample(blk, 0), 16'h7FFF);
    blk = '{8{16'h8000}};
    check("model_negzero", model_sample(blk, 2), 16'h0000);

    rdy_pct = 100;
    rdy_auto = 1'b1;
    @(posedge clk); #1;

    // DC block with latency probe
    blk = '{16'd800, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    lit = '{8{16'h0117}};
    push_lit(lit);
    send_block(blk, 0);
    @(negedge clk);
    check("latency_valid_after_E", out_valid, 1'b0);
    @(negedge clk);
    check("latency_valid_after_E1", out_valid, 1'b0);
    @(negedge clk);
    check("latency_valid_after_E2", out_valid, 1'b1);
    check("latency_first_data", out_data, 16'h0117);
    wait_drain();

    // Single AC term
    blk = '{16'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    lit = '{16'h01E9, 16'h01A3, 16'h0117, 16'h0063, 16'h8063, 16'h8117, 16'h81A3, 16'h81E9};
    push_lit(lit);
    send_block(blk, 0);
    wait_drain();

    // Negative DC
    blk = '{16'h8320, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    lit = '{8{16'h8117}};
    push_lit(lit);
    send_block(blk, 0);
    wait_drain();

    // Negative zero in every position
    blk = '{8{16'h8000}};
    lit = '{8{16'h0000}};
    push_lit(lit);
    send_block(blk, 1);
    wait_drain();

    // Saturation
    blk = '{8{16'h7FFF}};
    exp_q.push_back({1'b0, 16'h7FFF});
    for (int n = 1; n < 8; n++) exp_q.push_back({(n == 7) ? 1'b1 : 1'b0, model_sample(blk, n)});
    send_block(blk, 0);
    wait_drain();

    // Backpressure at x[3] with input pulses that must be ignored
    rdy_auto = 1'b0;
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int k = 0; k < 8; k++) blk[k] = rand_coef();
    push_model(blk);
    send_block(blk, 1);
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (hs_cnt >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_reached_x3", got, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, (exp_q.size() != 0) ? exp_q[0][15:0] : 16'hxxxx);
      check("bp_hold_last", out_last, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_no_extra_handshake", hs_cnt, 32'd3);
    rdy_auto = 1'b1;
    wait_drain();

    // Three random blocks streamed with gaps on both sides
    rdy_pct = 70;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) blk[k] = rand_coef();
      push_model(blk);
      send_block(blk, 3);
    end
    wait_drain();

    // Reset during OUTPUT after x[2] has been taken
    rdy_pct = 100;
    @(posedge clk); #1;
    mon_en = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 8; k++) blk[k] = rand_coef();
    blk[0] = 16'h4000;
    send_block(blk, 0);
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (hs_cnt >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_reached_x2", got, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_in_ready", in_ready, 1'b0);
    check("rst_mid_out_last", out_last, 1'b0);
    check("rst_mid_out_data", out_data, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    blk = '{16'd800, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    lit = '{8{16'h0117}};
    push_lit(lit);
    send_block(blk, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
